// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S microphone receiver.
// Default slot geometry matches the board's 24-in-32 bit MEMS microphone.
package i2s_pkg;

  localparam int SLOT_BITS   = 32;
  localparam int SAMPLE_BITS = 24;
  localparam int FRAME_BITS  = 2 * SLOT_BITS;

  typedef logic signed [SAMPLE_BITS-1:0] sample_t;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } ch_e;

endpackage

// File: rtl/i2s_clk_gen.sv
// SCK generator for the I2S receiver: divides clk by 2*CLK_DIV.
// Flags the clk cycle in which SCK is about to fall, so the top can sample and advance.
module i2s_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sck,
  output logic fall
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] div_cnt;
  logic          toggle;

  assign toggle = en && (div_cnt == CW'(CLK_DIV - 1));
  assign fall   = toggle && sck;

  // Disabling parks SCK low and restarts the divider, so re-enable begins a clean low phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (toggle) begin
      div_cnt <= '0;
      sck     <= ~sck;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_mic_rx.sv
// I2S master receiver for the MEMS microphone: drives SCK/WS and deserialises SD
// MSB first into one held, signed sample per slot with a single-cycle valid strobe.
module i2s_mic_rx #(
  parameter int CLK_DIV     = 4,
  parameter int SAMPLE_BITS = i2s_pkg::SAMPLE_BITS,
  parameter int SLOT_BITS   = i2s_pkg::SLOT_BITS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          sd,
  output logic                          sck,
  output logic                          ws,
  output logic signed [SAMPLE_BITS-1:0] sample,
  output logic                          sample_valid,
  output logic                          sample_right
);

  import i2s_pkg::*;

  // SLOT_BITS is a power of two, so the top bit of the frame counter is the slot.
  localparam int FRAME_LEN = 2 * SLOT_BITS;
  localparam int BW        = $clog2(FRAME_LEN);
  localparam int PW        = BW - 1;

  logic                   sd_meta;
  logic                   sd_s;
  logic                   fall;
  logic [BW-1:0]          bit_cnt;
  logic [PW-1:0]          pos;
  logic [SAMPLE_BITS-1:0] shreg;
  logic [SAMPLE_BITS-1:0] shifted;
  logic                   in_word;
  logic                   last_bit;
  ch_e                    slot_ch;

  i2s_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .sck   (sck),
    .fall  (fall)
  );

  assign ws       = bit_cnt[BW-1];
  assign pos      = bit_cnt[PW-1:0];
  assign slot_ch  = ch_e'(bit_cnt[BW-1]);
  assign shifted  = {shreg[SAMPLE_BITS-2:0], sd_s};
  assign in_word  = (pos != '0) && (pos <= PW'(SAMPLE_BITS));
  assign last_bit = (pos == PW'(SAMPLE_BITS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sd_meta <= 1'b0;
      sd_s    <= 1'b0;
    end else begin
      sd_meta <= sd;
      sd_s    <= sd_meta;
    end
  end

  // Frame position advances on SCK falling edges; the mic changes SD on those edges too,
  // so the synchronised bit seen at a fall was launched a full SCK period earlier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (!en) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (fall) begin
      bit_cnt <= (bit_cnt == BW'(FRAME_LEN - 1)) ? '0 : bit_cnt + 1'b1;
      if (pos == '0) begin
        shreg <= '0;
      end else if (in_word) begin
        shreg <= shifted;
      end
    end
  end

  // The final bit goes straight into the output so the strobe trails its fall event by one clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample       <= '0;
      sample_right <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (en && fall && last_bit) begin
        sample       <= shifted;
        sample_right <= slot_ch;
        sample_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_mic_rx.sv
// Directed bench for i2s_mic_rx: a behavioural microphone feeds known words and the
// captured samples, strobe timing and enable/reset behaviour are compared to hand values.
module tb_i2s_mic_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        sd = 1'b0;
  logic        sck;
  logic        ws;
  logic [23:0] sample;
  logic        sample_valid;
  logic        sample_right;

  logic        en2 = 1'b0;
  logic        sd2 = 1'b0;
  logic        sck2;
  logic        ws2;
  logic [23:0] sample2;
  logic        sample_valid2;
  logic        sample_right2;

  int          vectors = 0;
  int          miscompares = 0;

  logic [23:0] left_w = '0;
  logic [23:0] right_w = '0;
  logic        pad_b = 1'b0;
  int          mic_cnt = 0;
  int          mic_cnt2 = 0;

  bit          use2 = 1'b0;
  int          cyc = 0;
  int          base = 0;
  int          nbase = 0;
  int          nstb = 0;
  int          ws_rise = -1;
  logic        ws_q = 1'b0;
  logic [23:0] s_val [128];
  logic        s_ch [128];
  int          s_cyc [128];

  logic        rec_valid;
  logic [23:0] rec_sample;
  logic        rec_right;
  logic        rec_ws;

  i2s_mic_rx #(
    .CLK_DIV     (4),
    .SAMPLE_BITS (24),
    .SLOT_BITS   (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .sd           (sd),
    .sck          (sck),
    .ws           (ws),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_right (sample_right)
  );

  i2s_mic_rx #(
    .CLK_DIV     (2),
    .SAMPLE_BITS (24),
    .SLOT_BITS   (32)
  ) dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en2),
    .sd           (sd2),
    .sck          (sck2),
    .ws           (ws2),
    .sample       (sample2),
    .sample_valid (sample_valid2),
    .sample_right (sample_right2)
  );

  always #20 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Microphone bit for frame position c: MSB one SCK after the slot starts, then padding.
  function automatic logic mic_bit(int c);
    int          p;
    logic [23:0] w;
    p = c % 32;
    w = (c >= 32) ? right_w : left_w;
    if (p >= 1 && p <= 24) return w[24-p];
    return pad_b;
  endfunction

  always @(negedge sck or negedge en) begin
    if (!en) begin
      mic_cnt = 0;
    end else begin
      mic_cnt = (mic_cnt + 1) % 64;
      #20 sd = mic_bit(mic_cnt);
    end
  end

  always @(negedge sck2 or negedge en2) begin
    if (!en2) begin
      mic_cnt2 = 0;
    end else begin
      mic_cnt2 = (mic_cnt2 + 1) % 64;
      #20 sd2 = mic_bit(mic_cnt2);
    end
  end

  assign rec_valid  = use2 ? sample_valid2 : sample_valid;
  assign rec_sample = use2 ? sample2 : sample;
  assign rec_right  = use2 ? sample_right2 : sample_right;
  assign rec_ws     = use2 ? ws2 : ws;

  // Logs every strobe of the selected instance with its clk count, plus the latest WS rise.
  always @(negedge clk) begin
    if (rec_valid) begin
      if (nstb < 128) begin
        s_val[nstb] = rec_sample;
        s_ch[nstb]  = rec_right;
        s_cyc[nstb] = cyc;
      end
      nstb = nstb + 1;
    end
    if (rec_ws && !ws_q) ws_rise = cyc;
    ws_q = rec_ws;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors = vectors + 1;
    if (got !== exp) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Called just after a clk edge; that edge is clk 0 for all relative timing below.
  task automatic applyStimulus(input bit sel, input logic [23:0] l, input logic [23:0] r,
                               input logic pad);
    left_w  = l;
    right_w = r;
    pad_b   = pad;
    use2    = sel;
    base    = cyc;
    nbase   = nstb;
    if (sel) en2 = 1'b1;
    else     en  = 1'b1;
  endtask

  task automatic waitUntil(input int c);
    while (cyc - base < c) @(posedge clk);
    #1;
  endtask

  initial begin
    int sck_hi;

    // Reset values
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_sck", 32'(sck), 32'd0);
    checkOutput("rst_ws", 32'(ws), 32'd0);
    checkOutput("rst_sample", 32'(sample), 32'd0);
    checkOutput("rst_valid", 32'(sample_valid), 32'd0);
    checkOutput("rst_right", 32'(sample_right), 32'd0);
    rst_n = 1'b1;
    sck_hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (sck) sck_hi = 1;
    end
    checkOutput("idle_sck", 32'(sck_hi), 32'd0);

    // Single left word with padding ones
    @(posedge clk); #1;
    applyStimulus(1'b0, 24'hA5C3F1, 24'h000000, 1'b1);
    waitUntil(300);
    checkOutput("l_count", 32'(nstb - nbase), 32'd1);
    checkOutput("l_value", 32'(s_val[nbase]), 32'hA5C3F1);
    checkOutput("l_chan", 32'(s_ch[nbase]), 32'd0);
    checkOutput("l_latency", 32'(s_cyc[nbase] - base), 32'd200);
    checkOutput("ws_rise", 32'(ws_rise - base), 32'd256);
    en = 1'b0;
    repeat (4) @(posedge clk);

    // Full-scale left then right, strobe order and spacing
    #1;
    applyStimulus(1'b0, 24'h7FFFFF, 24'h800000, 1'b0);
    waitUntil(500);
    checkOutput("lr_count", 32'(nstb - nbase), 32'd2);
    checkOutput("lr_val0", 32'(s_val[nbase]), 32'h7FFFFF);
    checkOutput("lr_ch0", 32'(s_ch[nbase]), 32'd0);
    checkOutput("lr_cyc0", 32'(s_cyc[nbase] - base), 32'd200);
    checkOutput("lr_val1", 32'(s_val[nbase+1]), 32'h800000);
    checkOutput("lr_ch1", 32'(s_ch[nbase+1]), 32'd1);
    checkOutput("lr_space", 32'(s_cyc[nbase+1] - s_cyc[nbase]), 32'd256);
    en = 1'b0;
    repeat (4) @(posedge clk);

    // Disable in the middle of a left slot, then a clean re-enable
    #1;
    applyStimulus(1'b0, 24'h3C3C3C, 24'h000000, 1'b0);
    waitUntil(100);
    checkOutput("dis_sck_pre", 32'(sck), 32'd1);
    en = 1'b0;
    @(posedge clk); #1;
    checkOutput("dis_sck", 32'(sck), 32'd0);
    checkOutput("dis_ws", 32'(ws), 32'd0);
    repeat (300) @(posedge clk);
    #1;
    checkOutput("dis_count", 32'(nstb - nbase), 32'd0);
    checkOutput("dis_hold", 32'(sample), 32'h800000);
    checkOutput("dis_hold_ch", 32'(sample_right), 32'd1);
    applyStimulus(1'b0, 24'h123456, 24'h000000, 1'b0);
    waitUntil(220);
    checkOutput("re_count", 32'(nstb - nbase), 32'd1);
    checkOutput("re_value", 32'(s_val[nbase]), 32'h123456);
    checkOutput("re_chan", 32'(s_ch[nbase]), 32'd0);
    checkOutput("re_latency", 32'(s_cyc[nbase] - base), 32'd200);
    en = 1'b0;
    repeat (4) @(posedge clk);

    // Reset pulse at p=20 of a left slot
    #1;
    applyStimulus(1'b0, 24'h0F0F0F, 24'h000000, 1'b0);
    waitUntil(164);
    checkOutput("mr_hold", 32'(sample), 32'h123456);
    checkOutput("mr_sck_pre", 32'(sck), 32'd1);
    rst_n = 1'b0;
    #2;
    checkOutput("mr_sck", 32'(sck), 32'd0);
    checkOutput("mr_ws", 32'(ws), 32'd0);
    checkOutput("mr_sample", 32'(sample), 32'd0);
    checkOutput("mr_valid", 32'(sample_valid), 32'd0);
    checkOutput("mr_right", 32'(sample_right), 32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nbase = nstb;
    repeat (150) @(posedge clk);
    #1;
    checkOutput("mr_nostrobe", 32'(nstb - nbase), 32'd0);
    checkOutput("mr_sample_after", 32'(sample), 32'd0);
    en = 1'b0;
    repeat (4) @(posedge clk);

    // CLK_DIV=2, alternating words over 16 frames
    #1;
    applyStimulus(1'b1, 24'h555555, 24'hAAAAAA, 1'b0);
    waitUntil(4150);
    checkOutput("d2_count", 32'(nstb - nbase), 32'd32);
    checkOutput("d2_first", 32'(s_cyc[nbase] - base), 32'd100);
    checkOutput("d2_span", 32'(s_cyc[nbase+31] - s_cyc[nbase]), 32'd3968);
    for (int i = 0; i < 32; i++) begin
      checkOutput($sformatf("d2_val%0d", i), 32'(s_val[nbase+i]),
                  (i % 2 == 1) ? 32'hAAAAAA : 32'h555555);
      checkOutput($sformatf("d2_ch%0d", i), 32'(s_ch[nbase+i]), 32'(i % 2));
    end
    en2 = 1'b0;
    repeat (4) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
